// File: rtl/fir_stream_source.sv
// Burst test-pattern source feeding a FIR's AXI-Stream sample input.
// Patterns: impulse, step, ramp, LFSR; optional idle gap after each accepted sample.
module fir_stream_source #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned GAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  sample_cnt
);

    localparam logic [15:0]       SEED    = 16'hACE1;
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state, state_n;
    logic [1:0]         mode_q, mode_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [15:0]        lfsr, lfsr_n, lfsr_adv;
    logic [LEN_W-1:0]   cnt_n, cnt_inc;
    logic [DATA_W-1:0]  tdata_n;
    logic               tvalid_n, busy_n, done_n, handshake;

    // Fibonacci taps 16,14,13,11 in right-shift form (bits 0,2,3,5 feed bit 15)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [DATA_W-1:0] first_sample(input logic [1:0] m);
        case (m)
            2'd2:    return NEG_MIN;
            2'd3:    return SEED[DATA_W-1:0];
            default: return POS_MAX;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        len_n     = len_q;
        gap_n     = gap_q;
        gap_cnt_n = gap_cnt;
        lfsr_n    = lfsr;
        cnt_n     = sample_cnt;
        tdata_n   = m_axis_tdata;
        tvalid_n  = m_axis_tvalid;
        done_n    = 1'b0;
        handshake = m_axis_tvalid && m_axis_tready;
        lfsr_adv  = lfsr_step(lfsr);
        cnt_inc   = sample_cnt + LEN_W'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    mode_n   = mode;
                    len_n    = burst_len;
                    gap_n    = gap;
                    cnt_n    = '0;
                    lfsr_n   = SEED;
                    tdata_n  = first_sample(mode);
                    tvalid_n = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    cnt_n  = cnt_inc;
                    lfsr_n = lfsr_adv;
                    case (mode_q)
                        2'd0:    tdata_n = '0;
                        2'd1:    tdata_n = POS_MAX;
                        2'd2:    tdata_n = m_axis_tdata + DATA_W'(1);
                        default: tdata_n = lfsr_adv[DATA_W-1:0];
                    endcase
                    // burst_len of 0 means 2^LEN_W: the incremented count wraps to 0 exactly then
                    if (cnt_inc == len_q) begin
                        state_n  = DONE;
                        tvalid_n = 1'b0;
                        done_n   = 1'b1;
                    end else if (gap_q != '0) begin
                        state_n   = GAP;
                        tvalid_n  = 1'b0;
                        gap_cnt_n = gap_q;
                    end
                end
                if (abort) begin
                    state_n  = IDLE;
                    tvalid_n = 1'b0;
                    done_n   = 1'b0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_n  = SEND;
                    tvalid_n = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
                if (abort) begin
                    state_n  = IDLE;
                    tvalid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mode_q        <= '0;
            len_q         <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            lfsr          <= SEED;
            sample_cnt    <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            mode_q        <= mode_n;
            len_q         <= len_n;
            gap_q         <= gap_n;
            gap_cnt       <= gap_cnt_n;
            lfsr          <= lfsr_n;
            sample_cnt    <= cnt_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

endmodule

// File: tb/tb_fir_stream_source.sv
// Directed bench for fir_stream_source: all four patterns, gaps, stalls, abort, async reset.
module tb_fir_stream_source;

    logic       clk, reset, start, abort;
    logic [1:0] mode;
    logic [7:0] burst_len;
    logic [3:0] gap;
    logic [5:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready, busy, done;
    logic [7:0] sample_cnt;

    int errors = 0;
    int checks = 0;

    // low 6 bits of LFSR states ACE1, 5670, AB38, 559C, 2ACE
    int lf_exp[5] = '{33, 48, 56, 28, 14};
    bit step_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    fir_stream_source #(.DATA_W(6), .LEN_W(8), .GAP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .burst_len(burst_len), .gap(gap), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
        check({tag, "_tdata"}, 32'(m_axis_tdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cnt"}, 32'(sample_cnt), 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        burst_len = 8'd0; gap = 4'd0; m_axis_tready = 1'b1;

        #2 check_idle_outputs("reset");

        // impulse, len 4, start honoured on the first edge after release
        #1 reset = 1'b1; start = 1'b1; mode = 2'd0; burst_len = 8'd4; gap = 4'd0;
        tick();
        start = 1'b0; mode = 2'd1; burst_len = 8'd9; gap = 4'd3;
        check("imp_first", 32'(m_axis_tdata), 31);
        check("imp_valid", 32'(m_axis_tvalid), 1);
        check("imp_busy", 32'(busy), 1);
        check("imp_cnt0", 32'(sample_cnt), 0);
        repeat (3) begin
            tick();
            check("imp_zero", 32'(m_axis_tdata), 0);
            check("imp_valid_b2b", 32'(m_axis_tvalid), 1);
        end
        tick();
        check("imp_done", 32'(done), 1);
        check("imp_done_valid", 32'(m_axis_tvalid), 0);
        check("imp_cnt", 32'(sample_cnt), 4);
        tick();
        check("imp_done_pulse", 32'(done), 0);
        check("imp_idle_busy", 32'(busy), 0);
        check("imp_cnt_hold", 32'(sample_cnt), 4);

        // ramp, len 0 = 256 samples, wraps +31 -> -32 four times
        mode = 2'd2; burst_len = 8'd0; gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            check("ramp_tdata", 32'(m_axis_tdata), 32'((i + 32) % 64));
            check("ramp_valid", 32'(m_axis_tvalid), 1);
            tick();
        end
        check("ramp_done", 32'(done), 1);
        check("ramp_cnt_wrap", 32'(sample_cnt), 0);
        tick();

        // step, len 3, gap 2
        mode = 2'd1; burst_len = 8'd3; gap = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("step_valid", 32'(m_axis_tvalid), 32'(step_pat[i]));
            if (step_pat[i]) check("step_tdata", 32'(m_axis_tdata), 31);
            tick();
        end
        check("step_done", 32'(done), 1);
        check("step_cnt", 32'(sample_cnt), 3);
        tick();

        // LFSR, len 5, 3-cycle stalls before samples 0, 2, 4
        mode = 2'd3; burst_len = 8'd5; gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                m_axis_tready = 1'b0;
                repeat (3) begin
                    check("lfsr_stall_valid", 32'(m_axis_tvalid), 1);
                    check("lfsr_stall_tdata", 32'(m_axis_tdata), 32'(lf_exp[k]));
                    tick();
                end
                m_axis_tready = 1'b1;
            end
            check("lfsr_tdata", 32'(m_axis_tdata), 32'(lf_exp[k]));
            tick();
        end
        check("lfsr_done", 32'(done), 1);
        check("lfsr_cnt", 32'(sample_cnt), 5);
        tick();

        // ramp, len 10, abort after 3 handshakes
        mode = 2'd2; burst_len = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_pre_tdata", 32'(m_axis_tdata), 35);
        check("abort_pre_cnt", 32'(sample_cnt), 3);
        abort = 1'b1; m_axis_tready = 1'b0;
        tick();
        abort = 1'b0; m_axis_tready = 1'b1;
        check("abort_valid", 32'(m_axis_tvalid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_cnt", 32'(sample_cnt), 3);
        tick();
        check("abort_no_done", 32'(done), 0);
        check("abort_cnt_hold", 32'(sample_cnt), 3);

        // ramp, len 3, start pulsed mid-burst with a different mode
        mode = 2'd2; burst_len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_first", 32'(m_axis_tdata), 32);
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        check("ign_tdata1", 32'(m_axis_tdata), 33);
        check("ign_cnt1", 32'(sample_cnt), 1);
        tick();
        check("ign_tdata2", 32'(m_axis_tdata), 34);
        tick();
        check("ign_done", 32'(done), 1);
        check("ign_cnt", 32'(sample_cnt), 3);
        tick();
        check("ign_idle", 32'(busy), 0);

        // reset asserted mid-burst between edges
        mode = 2'd2; burst_len = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rst_pre_tdata", 32'(m_axis_tdata), 34);
        check("rst_pre_valid", 32'(m_axis_tvalid), 1);
        #2 reset = 1'b0;
        #1 check_idle_outputs("rst_mid");
        #2 reset = 1'b1; start = 1'b1; mode = 2'd2;
        tick();
        start = 1'b0;
        check("rst_restart_tdata", 32'(m_axis_tdata), 32);
        check("rst_restart_cnt", 32'(sample_cnt), 0);
        check("rst_restart_valid", 32'(m_axis_tvalid), 1);
        tick();
        check("rst_next_tdata", 32'(m_axis_tdata), 33);
        check("rst_next_cnt", 32'(sample_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_stream_source.md
FIR_STREAM_SOURCE -- requirements
Module: fir_stream_source

Interface
REQ-001 Parameter DATA_W, default 6: sample width, two's complement.
REQ-002 Parameter LEN_W, default 8: width of burst_len and sample_cnt.
REQ-003 Parameter GAP_W, default 4: width of gap.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a burst; sampled only in IDLE.
REQ-007 abort  input  1  synchronous abort of a running burst.
REQ-008 mode  input  2  pattern: 0 impulse, 1 step, 2 ramp, 3 LFSR.
REQ-009 burst_len  input  LEN_W  samples per burst; 0 means 2^LEN_W.
REQ-010 gap  input  GAP_W  idle cycles inserted after each accepted sample.
REQ-011 m_axis_tdata  output  DATA_W  signed sample to the FIR stream input.
REQ-012 m_axis_tvalid  output  1  sample valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 sample_cnt  output  LEN_W  samples accepted in the current or last burst.

Function
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 FSM states SHALL be IDLE, SEND, GAP, DONE.
REQ-019 IDLE: start=1 at an edge SHALL capture mode, burst_len and gap, clear sample_cnt, initialise the generator, enter SEND; tvalid=1 with the first sample in the next cycle (1-cycle latency).
REQ-020 Handshake SHALL occur on an edge where tvalid=1 and tready=1; sample_cnt increments by 1 (wraps modulo 2^LEN_W).
REQ-021 While tvalid=1 and tready=0, tdata and tvalid SHALL hold stable (abort excepted).
REQ-022 SEND on handshake: last sample (count reaches burst_len) -> DONE; else gap=0 -> stay SEND, next sample presented the following cycle (back-to-back, 1 sample/cycle); else -> GAP.
REQ-023 GAP: tvalid=0 for exactly gap cycles, then SEND with the next sample.
REQ-024 DONE: tvalid=0, done=1 for one cycle, then IDLE; sample_cnt holds its final value until the next start.
REQ-025 start outside IDLE SHALL be ignored; mode/burst_len/gap changes during a burst SHALL have no effect.
REQ-026 abort=1 in SEND or GAP SHALL force IDLE at the next edge: tvalid=0, no done pulse, sample_cnt keeps the handshakes completed; a handshake on the same edge is counted. Abort in IDLE/DONE: no effect.
REQ-027 Impulse: first sample +(2^(DATA_W-1)-1) (+31 at default), all later samples 0.
REQ-028 Step: every sample +(2^(DATA_W-1)-1).
REQ-029 Ramp: first sample -2^(DATA_W-1) (-32), +1 per handshake, wrapping +31 -> -32.
REQ-030 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at start, advanced once per handshake; tdata = low DATA_W bits of the state.
REQ-031 Generators SHALL advance only on handshakes, never on stalls or gaps.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, tvalid=0, tdata=0, busy=0, done=0, sample_cnt=0, LFSR=16'hACE1, including mid-burst.
REQ-033 After reset deassertion the first start SHALL be honoured at the first edge on which it is sampled high.

Verification
REQ-034 Impulse, burst_len=4, gap=0, tready=1: tdata 31,0,0,0 on 4 consecutive cycles; done pulses the cycle after the 4th handshake; sample_cnt=4.
REQ-035 Ramp, burst_len=0 (256), gap=0, tready=1: -32..31 four times, wraps correctly; 256 handshakes, sample_cnt=0 at done.
REQ-036 Step, burst_len=3, gap=2, tready=1: pattern valid,0,0,valid,0,0,valid then DONE; all samples 31.
REQ-037 LFSR, burst_len=5, tready toggled randomly with 3-cycle stalls: tdata/tvalid stable during stalls; 5 accepted samples equal low 6 bits of the first 5 LFSR states from 16'hACE1.
REQ-038 Ramp, burst_len=10: abort after 3 handshakes -> IDLE next edge, tvalid=0, no done, sample_cnt=3; start pulsed mid-burst in another run has no effect.
REQ-039 reset asserted mid-burst with tvalid=1: all outputs at reset values without waiting for clk; new start after release restarts the pattern from the first sample.
